// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_responder
//  Purpose  : Single-port word-addressed SRAM behind a valid/ready memory
//             port. Every accepted request completes with a fixed latency of
//             1+WAIT cycles and a one-cycle mem_ready pulse. Requests outside
//             the [BASE, BASE+4*DEPTH) window still complete; reads return 0
//             and writes are dropped.
//  Ports    : clk        - clock, all state on rising edge
//             rst        - asynchronous reset, active low
//             mem_valid  - request strobe from the initiator
//             mem_instr  - instruction-fetch qualifier (captured only)
//             mem_addr   - byte address, bits [1:0] ignored
//             mem_wdata  - write data
//             mem_wstrb  - byte write strobes, 4'b0000 selects a read
//             mem_ready  - one-cycle completion pulse
//             mem_rdata  - read data, non-zero only on a read completion
//  Revision : 1.0  initial release
// ============================================================================
module sram_responder #(
    parameter int          DEPTH = 4096,          // words, power of two, >= 4
    parameter logic [31:0] BASE  = 32'h0000_0000, // aligned to 4*DEPTH
    parameter int          WAIT  = 1              // extra wait cycles, 0..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [3:0]         cnt;
    logic [IDX_W-1:0]   cap_idx;
    logic               cap_hit;
    logic [31:0]        cap_wdata;
    logic [3:0]         cap_wstrb;
    logic               cap_instr;

    logic               accept;
    logic               req_hit;
    logic [IDX_W-1:0]   req_idx;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        ram_q;
    logic [IDX_W-1:0]   ram_idx;
    logic               ram_we;

    // BASE is aligned to the window size, so the window test reduces to an
    // upper-bit compare and the word index is simply the low address bits.
    assign req_hit = (mem_addr[31:IDX_W+2] == BASE[31:IDX_W+2]);
    assign req_idx = mem_addr[IDX_W+1:2];
    assign accept  = (state == S_IDLE) && mem_valid;

    // ------------------------------------------------------------------
    // FSM: state register and next-state / output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_valid) begin
                    state_nx = (WAIT > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // <= guards against a stuck counter should it ever read 0
                if (cnt <= 4'd1) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                mem_ready = 1'b1;
                state_nx  = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_hit   <= 1'b0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            cap_instr <= 1'b0;
        end else if (accept) begin
            cnt       <= WAIT_CNT;
            cap_idx   <= req_idx;
            cap_hit   <= req_hit;
            cap_wdata <= mem_wdata;
            cap_wstrb <= mem_wstrb;
            cap_instr <= mem_instr;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Synchronous single-port RAM, read-first, byte-lane writes.
    // A read is performed every cycle; the cycle before RESP is either the
    // accepting IDLE cycle (live address) or the last WAIT cycle (captured
    // address), so ram_q always holds the addressed word during RESP.
    // ------------------------------------------------------------------
    assign ram_idx = (state == S_IDLE) ? req_idx : cap_idx;
    assign ram_we  = (state == S_RESP) && cap_hit;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && cap_wstrb[b]) begin
                mem[ram_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
            end
        end
        ram_q <= mem[ram_idx];
    end

    // Only an in-range read completion exposes RAM data; state is reset
    // asynchronously, so this is forced to zero as soon as rst falls.
    assign mem_rdata = ((state == S_RESP) && cap_hit && (cap_wstrb == 4'd0))
                       ? ram_q : 32'd0;

    // The fetch qualifier has no effect on the data path; the address byte
    // offset is ignored by design.
    logic unused_ok;
    assign unused_ok = ^{cap_instr, mem_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_responder
//  Purpose  : Directed self-checking bench. Four responders share the
//             request bus (WAIT = 1, 0, 5, 15); each has its own mem_valid
//             so only one is ever addressed at a time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_responder;

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 5;
            default: return 15;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  ready;
    logic [31:0] rdata [4];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_responder #(
            .DEPTH (4096),
            .BASE  (32'h0000_0000),
            .WAIT  (wait_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_valid (valid[g]),
            .mem_instr (instr),
            .mem_addr  (addr),
            .mem_wdata (wdata),
            .mem_wstrb (wstrb),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One transaction on responder i, started at a negedge. drop_at > 0
    // lowers mem_valid after that many cycles; mutate scrambles the bus
    // right after acceptance. Checks latency, data, and single-cycle pulse.
    task automatic txn(input int i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_rd,
                       input int drop_at, input bit mutate, input string tag);
        int          lat;
        logic [31:0] rd;
        lat      = 0;
        rd       = 32'd0;
        addr     = a;
        wdata    = wd;
        wstrb    = ws;
        instr    = ~instr;
        valid[i] = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (ready[i]) begin
                lat = k;
                rd  = rdata[i];
            end else begin
                if (k == drop_at) valid[i] = 1'b0;
                if (mutate && k == 1) begin
                    addr  = a ^ 32'h4;
                    wdata = ~wd;
                    wstrb = ~ws;
                end
            end
        end
        valid[i] = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'(wait_of(i) + 1));
        chk({tag, "/rdata"}, 64'(rd), 64'(exp_rd));
        @(negedge clk);
        chk({tag, "/post"}, {31'd0, ready[i], rdata[i]}, 64'd0);
    endtask

    initial begin
        logic seen;
        rst   = 1'b0;
        valid = 4'd0;
        instr = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        wstrb = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset/ready", {60'd0, ready}, 64'd0);
        for (int i = 0; i < 4; i++) chk("reset/rdata", 64'(rdata[i]), 64'd0);
        rst = 1'b1;

        // WAIT=1: full write, read back, byte strobes
        txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, "w1_wr10");
        txn(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0, "w1_rd10");
        txn(0, 32'h10, 32'h11223344, 4'b0101, 32'h0, 0, 0, "w1_strb");
        txn(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 0, 0, "w1_rdstrb");

        // Address window boundaries
        txn(0, 32'h0,    32'h01020304, 4'hF, 32'h0, 0, 0, "w1_wr0");
        txn(0, 32'h4000, 32'h0,        4'h0, 32'h0, 0, 0, "oor_rd");
        txn(0, 32'h4000, 32'hAAAA5555, 4'hF, 32'h0, 0, 0, "oor_wr");
        txn(0, 32'h0,    32'h0,        4'h0, 32'h01020304, 0, 0, "oor_rd0");
        txn(0, 32'h3FFC, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, "top_wr");
        txn(0, 32'h3FFE, 32'h0,        4'h0, 32'hCAFEF00D, 0, 0, "top_rd");

        // WAIT=0: preload, then three back-to-back reads with valid held
        txn(1, 32'h0, 32'h11111111, 4'hF, 32'h0, 0, 0, "w0_wr0");
        txn(1, 32'h4, 32'h22222222, 4'hF, 32'h0, 0, 0, "w0_wr4");
        txn(1, 32'h8, 32'h33333333, 4'hF, 32'h0, 0, 0, "w0_wr8");
        addr = 32'h0; wstrb = 4'h0; valid[1] = 1'b1;
        @(negedge clk);
        chk("b2b/1", {31'd0, ready[1], rdata[1]}, {32'd1, 32'h11111111});
        addr = 32'h4;
        @(negedge clk);
        chk("b2b/gap1", {63'd0, ready[1]}, 64'd0);
        @(negedge clk);
        chk("b2b/2", {31'd0, ready[1], rdata[1]}, {32'd1, 32'h22222222});
        addr = 32'h8;
        @(negedge clk);
        chk("b2b/gap2", {63'd0, ready[1]}, 64'd0);
        @(negedge clk);
        chk("b2b/3", {31'd0, ready[1], rdata[1]}, {32'd1, 32'h33333333});
        valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b/end", {63'd0, ready[1]}, 64'd0);

        // WAIT=5: reset in the middle of a write aborts it
        txn(2, 32'h20, 32'h0, 4'hF, 32'h0, 0, 0, "w5_pre");
        addr = 32'h20; wdata = 32'h55AA55AA; wstrb = 4'hF; valid[2] = 1'b1;
        repeat (2) @(negedge clk);
        valid[2] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstmid/now", {31'd0, ready[2], rdata[2]}, 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | ready[2];
        end
        chk("rstmid/noready", {63'd0, seen}, 64'd0);
        txn(2, 32'h20, 32'h0, 4'h0, 32'h0, 0, 0, "rstmid_rd20");

        // Bus changes after acceptance are ignored
        txn(2, 32'h24, 32'h12345678, 4'hF, 32'h0, 0, 1, "mut_wr");
        txn(2, 32'h24, 32'h0, 4'h0, 32'h12345678, 0, 0, "mut_rd24");
        txn(2, 32'h20, 32'h0, 4'h0, 32'h0, 0, 0, "mut_rd20");

        // WAIT=15: full counter range, valid dropped early
        txn(3, 32'h40, 32'h0BADF00D, 4'hF, 32'h0, 0, 0, "w15_wr");
        txn(3, 32'h40, 32'h0, 4'h0, 32'h0BADF00D, 3, 0, "w15_drop");

        // Earlier responders kept their contents across the reset
        txn(0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0, 0, "keep_rd10");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
